router_1x3: RTL and testbench

Single-input, three-output packet router. Byte-serial packets arrive on one input port. A 2-bit address in the header byte steers each packet into one of three 16-deep output FIFOs. Each output is drained independently by its own read enable. The block computes even XOR parity over each packet and flags mismatches. It is the top-level switching element between a packet source and three consumer channels.

---
 rtl/router_1x3.sv | 260 ++++++++++++++++++++++++++
 tb/tb_router_1x3.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_1x3.sv
// router_1x3: byte-serial packet router steering each packet into one of three output FIFOs.
// Define ROUTER_SOFT_RESET_EN to add a per-output read timeout that flushes a stalled FIFO.

module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: storage is deliberately not reset; pointers and count define validity, so a reset
    // memory would only cost a reset tree across every entry.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module router_1x3 #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en_0,
    input  logic             rd_en_1,
    input  logic             rd_en_2,
    output logic             valid_out_0,
    output logic             valid_out_1,
    output logic             valid_out_2,
    output logic [WIDTH-1:0] data_out_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic [WIDTH-1:0] data_out_2,
    output logic             error,
    output logic             busy
);
    localparam logic [2:0] DECODE          = 3'd0;
    localparam logic [2:0] LOAD_FIRST      = 3'd1;
    localparam logic [2:0] LOAD_DATA       = 3'd2;
    localparam logic [2:0] WAIT_EMPTY      = 3'd3;
    localparam logic [2:0] FIFO_FULL       = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL = 3'd5;
    localparam logic [2:0] CHECK_PARITY    = 3'd6;
    localparam logic [2:0] DROP            = 3'd7;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] hdr;
    logic [WIDTH-1:0] hold_byte;
    logic             hold_last;
    logic [WIDTH-1:0] parity_acc;
    logic [WIDTH-1:0] parity_rx;
    logic [1:0]       tgt;
    logic [2:0]       fifo_empty;
    logic [2:0]       fifo_full;
    logic [2:0]       wr_en;
    logic [2:0]       rd_en;
    logic [2:0]       flush;
    logic [WIDTH-1:0] wr_data;
    logic             wr_req;
    logic             tgt_empty;
    logic             tgt_full;
    logic             in_empty;
    logic             abort;

    assign rd_en = {rd_en_2, rd_en_1, rd_en_0};
    assign tgt   = hdr[1:0];

    // NOTE: every combinational output gets a default before the case so no path infers a latch.
    always_comb begin
        tgt_empty = 1'b1;
        tgt_full  = 1'b0;
        in_empty  = 1'b1;
        case (tgt)
            2'd0:    begin tgt_empty = fifo_empty[0]; tgt_full = fifo_full[0]; end
            2'd1:    begin tgt_empty = fifo_empty[1]; tgt_full = fifo_full[1]; end
            2'd2:    begin tgt_empty = fifo_empty[2]; tgt_full = fifo_full[2]; end
            default: ;
        endcase
        case (data_in[1:0])
            2'd0:    in_empty = fifo_empty[0];
            2'd1:    in_empty = fifo_empty[1];
            2'd2:    in_empty = fifo_empty[2];
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DECODE: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == 2'd3) state_nxt = DROP;
                    else if (in_empty)        state_nxt = LOAD_FIRST;
                    else                      state_nxt = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY:      if (tgt_empty) state_nxt = LOAD_FIRST;
            LOAD_FIRST:      state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (tgt_full)        state_nxt = FIFO_FULL;
                else if (!pkt_valid) state_nxt = CHECK_PARITY;
            end
            FIFO_FULL:       if (!tgt_full) state_nxt = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: state_nxt = hold_last ? CHECK_PARITY : LOAD_DATA;
            CHECK_PARITY:    state_nxt = DECODE;
            DROP:            if (!pkt_valid) state_nxt = DECODE;
            default:         state_nxt = DECODE;
        endcase
        if (abort) state_nxt = DECODE;
    end

    // A byte caught by a full FIFO is parked in hold_byte and replayed from LOAD_AFTER_FULL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= DECODE;
            hdr        <= '0;
            hold_byte  <= '0;
            hold_last  <= 1'b0;
            parity_acc <= '0;
            parity_rx  <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                DECODE: if (pkt_valid) hdr <= data_in;
                LOAD_FIRST: begin
                    parity_acc <= hdr;
                    error      <= 1'b0;
                end
                LOAD_DATA: begin
                    if (pkt_valid) parity_acc <= parity_acc ^ data_in;
                    else           parity_rx  <= data_in;
                    if (tgt_full) begin
                        hold_byte <= data_in;
                        hold_last <= !pkt_valid;
                    end
                end
                CHECK_PARITY: error <= (parity_acc != parity_rx);
                default: ;
            endcase
        end
    end

    assign busy = state inside {WAIT_EMPTY, LOAD_FIRST, FIFO_FULL, LOAD_AFTER_FULL, CHECK_PARITY};

    assign wr_req = (state == LOAD_FIRST) || (state == LOAD_AFTER_FULL) ||
                    ((state == LOAD_DATA) && !tgt_full);

    always_comb begin
        wr_data = data_in;
        if (state == LOAD_FIRST)           wr_data = hdr;
        else if (state == LOAD_AFTER_FULL) wr_data = hold_byte;
    end

    assign wr_en[0] = wr_req && (tgt == 2'd0);
    assign wr_en[1] = wr_req && (tgt == 2'd1);
    assign wr_en[2] = wr_req && (tgt == 2'd2);

`ifdef ROUTER_SOFT_RESET_EN
    logic loading;
    logic tgt_flush;

    // Flush an output after 30 consecutive cycles of holding data that nobody reads.
    for (genvar i = 0; i < 3; i++) begin : g_tmo
        logic [4:0] cnt;
        logic       idle;
        assign idle     = !fifo_empty[i] && !rd_en[i];
        assign flush[i] = idle && (cnt == 5'd29);
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)                 cnt <= '0;
            else if (!idle || flush[i]) cnt <= '0;
            else                       cnt <= cnt + 1'b1;
        end
    end

    assign loading = state inside {LOAD_FIRST, LOAD_DATA, FIFO_FULL, LOAD_AFTER_FULL};

    always_comb begin
        tgt_flush = 1'b0;
        case (tgt)
            2'd0:    tgt_flush = flush[0];
            2'd1:    tgt_flush = flush[1];
            2'd2:    tgt_flush = flush[2];
            default: ;
        endcase
    end

    assign abort = loading && tgt_flush;
`else
    assign flush = '0;
    assign abort = 1'b0;
`endif

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO_0 (
        .clk(clk), .rstn(rstn), .flush(flush[0]), .wr_en(wr_en[0]), .wr_data(wr_data),
        .rd_en(rd_en[0]), .rd_data(data_out_0), .empty(fifo_empty[0]), .full(fifo_full[0])
    );

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO_1 (
        .clk(clk), .rstn(rstn), .flush(flush[1]), .wr_en(wr_en[1]), .wr_data(wr_data),
        .rd_en(rd_en[1]), .rd_data(data_out_1), .empty(fifo_empty[1]), .full(fifo_full[1])
    );

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) FIFO_2 (
        .clk(clk), .rstn(rstn), .flush(flush[2]), .wr_en(wr_en[2]), .wr_data(wr_data),
        .rd_en(rd_en[2]), .rd_data(data_out_2), .empty(fifo_empty[2]), .full(fifo_full[2])
    );

    assign valid_out_0 = !fifo_empty[0];
    assign valid_out_1 = !fifo_empty[1];
    assign valid_out_2 = !fifo_empty[2];
endmodule

// File: tb/tb_router_1x3.sv
// tb_router_1x3: scoreboard bench for router_1x3; a byte source honours busy, readers pop per-channel queues.
// Define ROUTER_SOFT_RESET_EN for both files to also exercise the read-timeout flush.

module tb_router_1x3;
    localparam int GUARD = 2000;

    logic       clk;
    logic       rstn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       rd_en_0, rd_en_1, rd_en_2;
    logic       valid_out_0, valid_out_1, valid_out_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       error;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic       model_error = 1'b0;
    logic [7:0] pl_buf [64];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    router_1x3 #(.DEPTH(16), .WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
        .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .error(error), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void exp_push(input int ch, input logic [7:0] b);
        case (ch)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic logic [7:0] exp_pop(input int ch);
        case (ch)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int exp_size(input int ch);
        case (ch)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic vout(input int ch);
        case (ch)
            0:       return valid_out_0;
            1:       return valid_out_1;
            default: return valid_out_2;
        endcase
    endfunction

    function automatic logic [7:0] dout(input int ch);
        case (ch)
            0:       return data_out_0;
            1:       return data_out_1;
            default: return data_out_2;
        endcase
    endfunction

    task automatic set_rd(input int ch, input logic v);
        case (ch)
            0:       rd_en_0 = v;
            1:       rd_en_1 = v;
            default: rd_en_2 = v;
        endcase
    endtask

    task automatic fill_payload(input int len);
        for (int i = 0; i < len; i++) pl_buf[i] = 8'($urandom_range(0, 255));
    endtask

    // Drives header, payload from pl_buf and parity, advancing only on negedges where busy is low.
    // tight=1 also checks the exact busy/error timing around the parity byte.
    task automatic send_packet(input logic [7:0] hdr, input bit bad, input bit tight);
        int         len;
        int         n;
        int         guard;
        logic [1:0] addr;
        logic [7:0] par;
        logic [7:0] bytes [66];
        bit         saw_busy;

        len  = int'(hdr[7:2]);
        addr = hdr[1:0];
        par  = hdr;
        bytes[0] = hdr;
        for (int i = 0; i < len; i++) begin
            bytes[i+1] = pl_buf[i];
            par        = par ^ pl_buf[i];
        end
        bytes[len+1] = bad ? ~par : par;
        if (addr != 2'd3) begin
            for (int i = 0; i <= len + 1; i++) exp_push(int'(addr), bytes[i]);
            model_error = bad;
        end

        guard = 0;
        @(negedge clk);
        while (busy && guard < GUARD) begin
            @(negedge clk);
            guard++;
        end
        pkt_valid = 1'b1;
        data_in   = bytes[0];
        n         = 0;
        saw_busy  = 1'b0;
        while (n < len + 1 && guard < GUARD) begin
            @(negedge clk);
            guard++;
            if (busy) saw_busy = 1'b1;
            else begin
                n++;
                data_in   = bytes[n];
                pkt_valid = (n <= len);
            end
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        data_in   = 8'h00;

        if (addr == 2'd3) begin
            checks++;
            if (saw_busy || busy !== 1'b0) begin
                errors++;
                $display("FAIL drop_busy: busy seen high during dropped packet (busy now %b), required 0", busy);
            end
        end
        if (tight) begin
            checks++;
            if (busy !== (addr != 2'd3) || error !== (addr == 2'd3 ? model_error : 1'b0)) begin
                errors++;
                $display("FAIL parity_write_cycle hdr=%h: busy=%b error=%b, required busy=%b error=%b",
                         hdr, busy, error, (addr != 2'd3), (addr == 2'd3 ? model_error : 1'b0));
            end
            if (addr != 2'd3) @(negedge clk);
        end else begin
            while (busy && guard < GUARD) begin
                @(negedge clk);
                guard++;
            end
        end
        checks++;
        if (guard >= GUARD) begin
            errors++;
            $display("FAIL send_timeout hdr=%h: source stalled for %0d cycles, required fewer than %0d", hdr, guard, GUARD);
        end else if (busy !== 1'b0 || error !== model_error) begin
            errors++;
            $display("FAIL packet_end hdr=%h: busy=%b error=%b, required busy=0 error=%b", hdr, busy, error, model_error);
        end
    endtask

    // Holds rd_en on one channel until every expected byte for it has been compared.
    task automatic drain(input int ch, input int budget);
        logic       was_valid;
        logic [7:0] exp_b;
        int         n;
        @(negedge clk);
        set_rd(ch, 1'b1);
        was_valid = vout(ch);
        n = 0;
        while (exp_size(ch) > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (was_valid) begin
                exp_b = exp_pop(ch);
                checks++;
                if (dout(ch) !== exp_b) begin
                    errors++;
                    $display("FAIL read_data ch%0d: data_out=%h, required %h", ch, dout(ch), exp_b);
                end
            end
            was_valid = vout(ch);
        end
        set_rd(ch, 1'b0);
        checks++;
        if (exp_size(ch) != 0) begin
            errors++;
            $display("FAIL drain_timeout ch%0d: %0d bytes never arrived, required 0", ch, exp_size(ch));
        end
    endtask

    task automatic check_valids(input string name, input logic [2:0] required);
        checks++;
        if ({valid_out_2, valid_out_1, valid_out_0} !== required) begin
            errors++;
            $display("FAIL %s: valid_out_2..0=%b, required %b", name, {valid_out_2, valid_out_1, valid_out_0}, required);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
        rd_en_0 = 1'b0; rd_en_1 = 1'b0; rd_en_2 = 1'b0;
        repeat (3) @(negedge clk);
        check_valids("reset_valid", 3'b000);
        checks++;
        if ({data_out_0, data_out_1, data_out_2} !== 24'h0 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data_out=%h/%h/%h error=%b busy=%b, required all 0",
                     data_out_0, data_out_1, data_out_2, error, busy);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single;
        fill_payload(5);
        send_packet(8'h16, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_valids("single_stored", 3'b100);
        drain(2, 100);
        check_valids("single_drained", 3'b000);
    endtask

    task automatic test_bad_parity;
        fill_payload(5);
        send_packet(8'h16, 1'b1, 1'b1);
        drain(2, 100);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_hold: error=%b, required 1", error);
        end
    endtask

    task automatic test_drop;
        fill_payload(2);
        send_packet(8'h0B, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_valids("drop_nothing_stored", 3'b000);
        fill_payload(4);
        send_packet(8'h10, 1'b0, 1'b1);
        check_valids("after_drop_routed", 3'b001);
        drain(0, 100);
    endtask

    task automatic test_fifo_full;
        fill_payload(20);
        fork
            send_packet(8'h51, 1'b0, 1'b0);
            begin
                repeat (25) @(negedge clk);
                checks++;
                if (busy !== 1'b1 || dut.FIFO_1.full !== 1'b1 || valid_out_1 !== 1'b1) begin
                    errors++;
                    $display("FAIL full_stall: busy=%b full=%b valid_out_1=%b, required 1/1/1",
                             busy, dut.FIFO_1.full, valid_out_1);
                end
                drain(1, 400);
            end
        join
        check_valids("full_drained", 3'b000);
    endtask

    task automatic test_wait_empty;
        fill_payload(3);
        send_packet(8'h0C, 1'b0, 1'b1);
        fill_payload(2);
        fork
            send_packet(8'h08, 1'b0, 1'b0);
            begin
                repeat (10) @(negedge clk);
                checks++;
                if (busy !== 1'b1 || valid_out_0 !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_empty_hold: busy=%b valid_out_0=%b, required 1/1", busy, valid_out_0);
                end
                drain(0, 200);
            end
        join
        check_valids("wait_empty_drained", 3'b000);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        pkt_valid = 1'b1;
        data_in   = 8'h16;
        repeat (4) begin
            @(negedge clk);
            if (!busy) data_in = 8'($urandom_range(0, 255));
        end
        #2 rstn = 1'b0;
        #1;
        check_valids("mid_reset_valid", 3'b000);
        checks++;
        if (busy !== 1'b0 || error !== 1'b0 || data_out_2 !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b error=%b data_out_2=%h, required 0/0/00", busy, error, data_out_2);
        end
        model_error = 1'b0;
        @(negedge clk);
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        rstn      = 1'b1;
        repeat (3) @(negedge clk);
        check_valids("mid_reset_discarded", 3'b000);
    endtask

`ifdef ROUTER_SOFT_RESET_EN
    task automatic test_soft_reset;
        int n;
        fill_payload(2);
        send_packet(8'h08, 1'b0, 1'b1);
        n = 0;
        while (valid_out_0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (valid_out_0 !== 1'b0 || n < 22 || n > 30) begin
            errors++;
            $display("FAIL soft_reset_timing: valid_out_0=%b after %0d cycles, required 0 within 22..30", valid_out_0, n);
        end
        checks++;
        if (dut.FIFO_0.empty !== 1'b1 || data_out_0 !== 8'h00) begin
            errors++;
            $display("FAIL soft_reset_flush: empty=%b data_out_0=%h, required 1/00", dut.FIFO_0.empty, data_out_0);
        end
        q0.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_bad_parity();
        test_drop();
        test_fifo_full();
        test_wait_empty();
        test_reset_mid();
`ifdef ROUTER_SOFT_RESET_EN
        test_soft_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
